// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl: memory-mapped IO slave for the MIPS150 core.
// Sits behind the datapath's memory-map decode and turns X-stage IO loads and
// stores into register accesses. Load data is registered so it appears in the
// M stage with the same one-cycle latency as DMEM. Bytes move between the core
// and an external UART through a TX FIFO and an RX FIFO.
// Optional feature macro: MMIO_COUNTERS_EN adds the CYCLE and INSTR counters;
// without it those offsets read as zero and writes to them are ignored.
module mmio_uart_ctrl #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [3:0]  IO_BASE    = 4'h8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] io_addr,
   input  logic [3:0]  io_we,
   input  logic        io_re,
   input  logic [31:0] io_wdata,
   output logic [31:0] io_rdata,
   input  logic        instr_retire,
   output logic [7:0]  ua_tx_data,
   output logic        ua_tx_valid,
   input  logic        ua_tx_ready,
   input  logic [7:0]  ua_rx_data,
   input  logic        ua_rx_valid,
   output logic        ua_rx_ready
);

   localparam int unsigned AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   // Register offsets expressed as word indices (io_addr[7:2])
   localparam logic [5:0] OFF_STATUS = 6'h00;
   localparam logic [5:0] OFF_RXDATA = 6'h01;
   localparam logic [5:0] OFF_TXDATA = 6'h02;
   localparam logic [5:0] OFF_CYCLE  = 6'h04;
   localparam logic [5:0] OFF_INSTR  = 6'h05;

   logic        sel;
   logic [5:0]  wordOff;
   logic        anyWrite;
   logic        statusRead;
   logic        rxRead;
   logic        txWrite;
   logic        cycleWrite;
   logic        instrWrite;

   logic [7:0]  txMem_q [FIFO_DEPTH];
   logic [AW:0] txWrPtr_q, txWrPtr_d;
   logic [AW:0] txRdPtr_q, txRdPtr_d;
   logic        txEmpty, txFull, txPop, txPush, txDrop;

   logic [7:0]  rxMem_q [FIFO_DEPTH];
   logic [AW:0] rxWrPtr_q, rxWrPtr_d;
   logic [AW:0] rxRdPtr_q, rxRdPtr_d;
   logic        rxEmpty, rxFull, rxPop, rxPush;

   logic [31:0] readWord;
   logic [31:0] rdata_q, rdata_d;
   logic        overflow_q, overflow_d;
   logic [31:0] cycleCount;
   logic [31:0] instrCount;

   logic        unusedInputBits;

   assign unusedInputBits = ^{io_addr[27:8], io_addr[1:0], io_wdata[31:8]};

   // Address decode: the top nibble selects the block, bits 7:2 pick the word
   assign sel        = (io_addr[31:28] == IO_BASE);
   assign wordOff    = io_addr[7:2];
   assign anyWrite   = (io_we != 4'b0000);
   assign statusRead = sel && io_re && (wordOff == OFF_STATUS);
   assign rxRead     = sel && io_re && (wordOff == OFF_RXDATA);
   assign txWrite    = sel && anyWrite && (wordOff == OFF_TXDATA);
   assign cycleWrite = sel && anyWrite && (wordOff == OFF_CYCLE);
   assign instrWrite = sel && anyWrite && (wordOff == OFF_INSTR);

   // TX FIFO: full when indices match but the wrap bits differ. A pop in the
   // same cycle frees a slot, so a store to a full FIFO is still accepted.
   assign txEmpty   = (txWrPtr_q == txRdPtr_q);
   assign txFull    = (txWrPtr_q[AW-1:0] == txRdPtr_q[AW-1:0]) &&
                      (txWrPtr_q[AW] != txRdPtr_q[AW]);
   assign txPop     = !txEmpty && ua_tx_ready;
   assign txPush    = txWrite && (!txFull || txPop);
   assign txDrop    = txWrite && txFull && !txPop;
   assign txRdPtr_d = txPop  ? (txRdPtr_q + PTR_ONE) : txRdPtr_q;
   assign txWrPtr_d = txPush ? (txWrPtr_q + PTR_ONE) : txWrPtr_q;

   assign ua_tx_valid = !txEmpty;
   assign ua_tx_data  = txMem_q[txRdPtr_q[AW-1:0]];

   // RX FIFO: ready follows the stored fill level; a byte offered while full
   // is still taken when a core read frees the head slot on the same edge.
   assign rxEmpty   = (rxWrPtr_q == rxRdPtr_q);
   assign rxFull    = (rxWrPtr_q[AW-1:0] == rxRdPtr_q[AW-1:0]) &&
                      (rxWrPtr_q[AW] != rxRdPtr_q[AW]);
   assign rxPop     = rxRead && !rxEmpty;
   assign rxPush    = ua_rx_valid && (!rxFull || rxPop);
   assign rxRdPtr_d = rxPop  ? (rxRdPtr_q + PTR_ONE) : rxRdPtr_q;
   assign rxWrPtr_d = rxPush ? (rxWrPtr_q + PTR_ONE) : rxWrPtr_q;

   assign ua_rx_ready = !rxFull;

   // Byte storage has no reset; the pointers alone decide which entries are live
   always_ff @(posedge clk) begin
      if (txPush) begin
         txMem_q[txWrPtr_q[AW-1:0]] <= io_wdata[7:0];
      end
      if (rxPush) begin
         rxMem_q[rxWrPtr_q[AW-1:0]] <= ua_rx_data;
      end
   end

   // Read mux and next-state for load data and the sticky overflow flag
   always_comb begin
      readWord = 32'h0;
      if (sel) begin
         case (wordOff)
            OFF_STATUS: readWord = {29'h0, overflow_q, !rxEmpty, !txFull};
            OFF_RXDATA: readWord = rxEmpty ? 32'h0 : {24'h0, rxMem_q[rxRdPtr_q[AW-1:0]]};
            OFF_CYCLE:  readWord = cycleCount;
            OFF_INSTR:  readWord = instrCount;
            default:    readWord = 32'h0;
         endcase
      end
      rdata_d    = io_re ? readWord : rdata_q;
      overflow_d = overflow_q;
      if (statusRead) begin
         overflow_d = 1'b0;
      end
      if (txDrop) begin
         overflow_d = 1'b1;
      end
   end

   // Pointer, load-data and overflow registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         txWrPtr_q  <= '0;
         txRdPtr_q  <= '0;
         rxWrPtr_q  <= '0;
         rxRdPtr_q  <= '0;
         rdata_q    <= 32'h0;
         overflow_q <= 1'b0;
      end else begin
         txWrPtr_q  <= txWrPtr_d;
         txRdPtr_q  <= txRdPtr_d;
         rxWrPtr_q  <= rxWrPtr_d;
         rxRdPtr_q  <= rxRdPtr_d;
         rdata_q    <= rdata_d;
         overflow_q <= overflow_d;
      end
   end

   assign io_rdata = rdata_q;

`ifdef MMIO_COUNTERS_EN
   logic [31:0] cycle_q, cycle_d;
   logic [31:0] instr_q, instr_d;

   // A write clears a counter and swallows that cycle's increment
   always_comb begin
      cycle_d = cycleWrite ? 32'h0 : (cycle_q + 32'd1);
      instr_d = instrWrite ? 32'h0 : (instr_retire ? (instr_q + 32'd1) : instr_q);
   end

   // Counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q <= 32'h0;
         instr_q <= 32'h0;
      end else begin
         cycle_q <= cycle_d;
         instr_q <= instr_d;
      end
   end

   assign cycleCount = cycle_q;
   assign instrCount = instr_q;
`else
   logic unusedCounterInputs;

   assign unusedCounterInputs = ^{instr_retire, cycleWrite, instrWrite};
   assign cycleCount          = 32'h0;
   assign instrCount          = 32'h0;
`endif

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// tb_mmio_uart_ctrl: directed and randomized checks of mmio_uart_ctrl against a
// queue-based reference model of the register map, FIFOs and counters.
module tb_mmio_uart_ctrl;

   localparam int DEPTH = 8;
`ifdef MMIO_COUNTERS_EN
   localparam bit COUNTERS_ON = 1'b1;
`else
   localparam bit COUNTERS_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] io_addr;
   logic [3:0]  io_we;
   logic        io_re;
   logic [31:0] io_wdata;
   logic [31:0] io_rdata;
   logic        instr_retire;
   logic [7:0]  ua_tx_data;
   logic        ua_tx_valid;
   logic        ua_tx_ready;
   logic [7:0]  ua_rx_data;
   logic        ua_rx_valid;
   logic        ua_rx_ready;

   int evalCount = 0;
   int failCount = 0;

   // Reference model state
   logic [7:0]  txQ[$];
   logic [7:0]  rxQ[$];
   logic        mOverflow;
   logic [31:0] mRdata;
   logic [31:0] mCycle;
   logic [31:0] mInstr;

   mmio_uart_ctrl #(.FIFO_DEPTH(DEPTH), .IO_BASE(4'h8)) dut (
      .clk          (clk),
      .rst          (rst),
      .io_addr      (io_addr),
      .io_we        (io_we),
      .io_re        (io_re),
      .io_wdata     (io_wdata),
      .io_rdata     (io_rdata),
      .instr_retire (instr_retire),
      .ua_tx_data   (ua_tx_data),
      .ua_tx_valid  (ua_tx_valid),
      .ua_tx_ready  (ua_tx_ready),
      .ua_rx_data   (ua_rx_data),
      .ua_rx_valid  (ua_rx_valid),
      .ua_rx_ready  (ua_rx_ready)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      evalCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idleInputs();
      rst          = 1'b0;
      io_addr      = 32'h0;
      io_we        = 4'h0;
      io_re        = 1'b0;
      io_wdata     = 32'h0;
      instr_retire = 1'b0;
      ua_tx_ready  = 1'b0;
      ua_rx_data   = 8'h0;
      ua_rx_valid  = 1'b0;
   endtask

   task automatic modelReset();
      txQ.delete();
      rxQ.delete();
      mOverflow = 1'b0;
      mRdata    = 32'h0;
      mCycle    = 32'h0;
      mInstr    = 32'h0;
   endtask

   // Runs one clock with the inputs currently driven, checks the UART-side
   // outputs before the edge and the load data after it, and advances the model.
   task automatic applyStimulus();
      logic        sel;
      logic [7:0]  off;
      logic [31:0] expRd;
      logic        doRst, txPop, rxPop, txPush, cycWr, instWr, retire, rxOffer, statRd;
      logic [7:0]  txByte, rxByte;
      sel = (io_addr[31:28] == 4'h8);
      off = io_addr[7:0];
      checkOutput("txValid", {31'h0, ua_tx_valid}, {31'h0, (txQ.size() != 0)});
      if (txQ.size() != 0) checkOutput("txData", {24'h0, ua_tx_data}, {24'h0, txQ[0]});
      checkOutput("rxReady", {31'h0, ua_rx_ready}, {31'h0, (rxQ.size() < DEPTH)});
      expRd = mRdata;
      if (io_re) begin
         expRd = 32'h0;
         if (sel) begin
            case (off)
               8'h00: expRd = {29'h0, mOverflow, (rxQ.size() != 0), (txQ.size() < DEPTH)};
               8'h04: expRd = (rxQ.size() != 0) ? {24'h0, rxQ[0]} : 32'h0;
               8'h10: expRd = COUNTERS_ON ? mCycle : 32'h0;
               8'h14: expRd = COUNTERS_ON ? mInstr : 32'h0;
               default: expRd = 32'h0;
            endcase
         end
      end
      doRst   = rst;
      txPop   = (txQ.size() != 0) && ua_tx_ready;
      rxPop   = io_re && sel && (off == 8'h04) && (rxQ.size() != 0);
      statRd  = io_re && sel && (off == 8'h00);
      txPush  = sel && (io_we != 4'h0) && (off == 8'h08);
      cycWr   = sel && (io_we != 4'h0) && (off == 8'h10);
      instWr  = sel && (io_we != 4'h0) && (off == 8'h14);
      retire  = instr_retire;
      rxOffer = ua_rx_valid;
      txByte  = io_wdata[7:0];
      rxByte  = ua_rx_data;
      @(posedge clk);
      if (doRst) begin
         modelReset();
      end else begin
         if (statRd) mOverflow = 1'b0;
         if (txPop) void'(txQ.pop_front());
         if (txPush) begin
            if (txQ.size() < DEPTH) txQ.push_back(txByte);
            else mOverflow = 1'b1;
         end
         if (rxPop) void'(rxQ.pop_front());
         if (rxOffer && (rxQ.size() < DEPTH)) rxQ.push_back(rxByte);
         mRdata = expRd;
         mCycle = cycWr ? 32'h0 : (mCycle + 32'd1);
         mInstr = instWr ? 32'h0 : (mInstr + {31'h0, retire});
      end
      #1;
      checkOutput("rdata", io_rdata, mRdata);
   endtask

   task automatic readReg(input logic [31:0] addr);
      idleInputs();
      io_addr = addr;
      io_re   = 1'b1;
      applyStimulus();
      idleInputs();
   endtask

   task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
      idleInputs();
      io_addr  = addr;
      io_we    = 4'hF;
      io_wdata = data;
      applyStimulus();
      idleInputs();
   endtask

   // Directed test plan, randomized traffic, then a mid-operation reset
   initial begin
      logic [31:0] addrTable [9];
      addrTable = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_0008,
                    32'h8000_000C, 32'h8000_0010, 32'h8000_0014, 32'h0000_0004,
                    32'h9000_0008};

      idleInputs();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();

      checkOutput("resetRdata", io_rdata, 32'h0);
      checkOutput("resetRxReady", {31'h0, ua_rx_ready}, 32'h1);
      checkOutput("resetTxValid", {31'h0, ua_tx_valid}, 32'h0);
      readReg(32'h8000_0000);
      checkOutput("statusAfterReset", io_rdata, 32'h0000_0001);

      writeReg(32'h8000_0008, 32'h0000_00A5);
      checkOutput("txValidA5", {31'h0, ua_tx_valid}, 32'h1);
      checkOutput("txDataA5", {24'h0, ua_tx_data}, 32'h0000_00A5);
      ua_tx_ready = 1'b1;
      applyStimulus();
      idleInputs();
      checkOutput("txDrainedA5", {31'h0, ua_tx_valid}, 32'h0);

      for (int i = 1; i <= 9; i++) writeReg(32'h8000_0008, i);
      readReg(32'h8000_0000);
      checkOutput("statusOverflow", io_rdata, 32'h0000_0004);
      ua_tx_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         checkOutput("txDrainOrder", {24'h0, ua_tx_data}, {24'h0, 8'(i)});
         applyStimulus();
      end
      idleInputs();
      readReg(32'h8000_0000);
      checkOutput("statusAfterDrain", io_rdata, 32'h0000_0001);

      ua_rx_valid = 1'b1;
      ua_rx_data  = 8'h3C;
      applyStimulus();
      ua_rx_data  = 8'h7E;
      applyStimulus();
      idleInputs();
      readReg(32'h8000_0000);
      checkOutput("statusRxTwo", io_rdata, 32'h0000_0003);
      readReg(32'h8000_0004);
      checkOutput("rxFirst", io_rdata, 32'h0000_003C);
      readReg(32'h8000_0004);
      checkOutput("rxSecond", io_rdata, 32'h0000_007E);
      readReg(32'h8000_0004);
      checkOutput("rxEmptyRead", io_rdata, 32'h0);
      readReg(32'h8000_0000);
      checkOutput("statusRxDone", io_rdata, 32'h0000_0001);

      for (int i = 0; i < 8; i++) begin
         ua_rx_valid = 1'b1;
         ua_rx_data  = 8'h10 + 8'(i);
         applyStimulus();
      end
      idleInputs();
      checkOutput("rxFullReady", {31'h0, ua_rx_ready}, 32'h0);
      io_addr     = 32'h8000_0004;
      io_re       = 1'b1;
      ua_rx_valid = 1'b1;
      ua_rx_data  = 8'hEE;
      applyStimulus();
      idleInputs();
      checkOutput("rxPopPushData", io_rdata, 32'h0000_0010);
      checkOutput("rxPopPushReady", {31'h0, ua_rx_ready}, 32'h0);
      for (int i = 1; i <= 8; i++) begin
         readReg(32'h8000_0004);
         checkOutput("rxAfterPopPush", io_rdata, (i == 8) ? 32'h0000_00EE : {24'h0, 8'h10 + 8'(i)});
      end

      writeReg(32'h8000_0010, 32'h1234_5678);
      repeat (9) applyStimulus();
      readReg(32'h8000_0010);
      checkOutput("cycleCount", io_rdata, COUNTERS_ON ? 32'd9 : 32'd0);
      writeReg(32'h8000_0014, 32'h0);
      for (int i = 0; i < 5; i++) begin
         instr_retire = 1'b1;
         applyStimulus();
         instr_retire = 1'b0;
         applyStimulus();
      end
      readReg(32'h8000_0014);
      checkOutput("instrCount", io_rdata, COUNTERS_ON ? 32'd5 : 32'd0);
      readReg(32'h8000_000C);
      checkOutput("unmappedRead", io_rdata, 32'h0);

      for (int n = 0; n < 400; n++) begin
         idleInputs();
         io_addr      = addrTable[$urandom_range(0, 8)];
         io_re        = ($urandom_range(0, 9) < 4);
         io_we        = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         io_wdata     = $urandom;
         instr_retire = $urandom_range(0, 1) == 1;
         ua_tx_ready  = ($urandom_range(0, 2) == 0);
         ua_rx_valid  = $urandom_range(0, 1) == 1;
         ua_rx_data   = 8'($urandom);
         applyStimulus();
      end

      idleInputs();
      for (int i = 0; i < 3; i++) writeReg(32'h8000_0008, 32'h40 + i);
      ua_rx_valid = 1'b1;
      ua_rx_data  = 8'h99;
      applyStimulus();
      idleInputs();
      rst = 1'b1;
      applyStimulus();
      idleInputs();
      checkOutput("midResetTxValid", {31'h0, ua_tx_valid}, 32'h0);
      checkOutput("midResetRxReady", {31'h0, ua_rx_ready}, 32'h1);
      checkOutput("midResetRdata", io_rdata, 32'h0);
      readReg(32'h8000_0000);
      checkOutput("midResetStatus", io_rdata, 32'h0000_0001);
      readReg(32'h8000_0004);
      checkOutput("midResetRxEmpty", io_rdata, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", evalCount, failCount);
      $finish;
   end

endmodule
